// File: rtl/single_cycle_cpu.sv
// Single-cycle 32-bit MIPS-subset core: PC, instruction ROM, register file, ALU, branch/jump, data RAM.
// Optional feature: define SC_JUMP_EN to implement j (opcode 000010); otherwise it decodes as a nop.
module single_cycle_cpu #(
    parameter int unsigned IMEM_WORDS = 64,
    parameter int unsigned DMEM_WORDS = 32
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc_out
);
    localparam int unsigned IMEM_AW = $clog2(IMEM_WORDS);
    localparam int unsigned DMEM_AW = $clog2(DMEM_WORDS);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [1:0] AOP_ADD   = 2'd0;
    localparam logic [1:0] AOP_SUB   = 2'd1;
    localparam logic [1:0] AOP_FUNCT = 2'd2;
    localparam logic [1:0] AOP_AND   = 2'd3;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;

    logic [31:0] PC_out;
    // ROM image is preloaded by the environment (memory init at build, backdoor in simulation)
    logic [31:0] r_imem [0:IMEM_WORDS-1];
    logic [31:0] r_dmem [0:DMEM_WORDS-1];

    logic [31:0]        w_instr;
    logic               w_in_range;
    logic [IMEM_AW-1:0] w_imem_idx;
    logic [5:0]         w_opcode;
    logic [4:0]         w_rs;
    logic [4:0]         w_rt;
    logic [4:0]         w_rd;
    logic [5:0]         w_funct;
    logic [15:0]        w_imm;
    logic [31:0]        w_imm_sext;
    logic [31:0]        w_imm_zext;

    logic       w_reg_write;
    logic       w_reg_dst;
    logic       w_alu_src;
    logic       w_ext_zero;
    logic       w_mem_to_reg;
    logic       w_mem_write;
    logic       w_branch_eq;
    logic       w_branch_ne;
    logic       w_jump;
    logic [1:0] w_alu_op;
    logic [2:0] w_alu_ctrl;
    logic       w_funct_ok;

    logic [31:0]        w_rd1;
    logic [31:0]        w_rd2;
    logic [31:0]        w_alu_b;
    logic [31:0]        w_alu_result;
    logic [31:0]        w_wb_data;
    logic [4:0]         w_wb_addr;
    logic [DMEM_AW-1:0] w_dmem_idx;
    logic [31:0]        w_dmem_rdata;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_branch_target;
    logic [31:0] w_jump_target;
    logic        w_take_branch;
    logic [31:0] w_next_pc;
    logic        w_unused_pc_lsb;

    assign pc_out = PC_out;

    // Fetch; addresses past the ROM read as nop instead of aliasing
    assign w_imem_idx      = PC_out[IMEM_AW+1:2];
    assign w_in_range      = (PC_out[31:2] < 30'(IMEM_WORDS));
    assign w_instr         = w_in_range ? r_imem[w_imem_idx] : 32'd0;
    assign w_unused_pc_lsb = ^PC_out[1:0];

    assign w_opcode   = w_instr[31:26];
    assign w_rs       = w_instr[25:21];
    assign w_rt       = w_instr[20:16];
    assign w_rd       = w_instr[15:11];
    assign w_funct    = w_instr[5:0];
    assign w_imm      = w_instr[15:0];
    assign w_imm_sext = {{16{w_imm[15]}}, w_imm};
    assign w_imm_zext = {16'd0, w_imm};

    // ALU control; also flags whether an R-type funct is supported
    always_comb begin
        w_alu_ctrl = ALU_ADD;
        w_funct_ok = 1'b0;
        case (w_alu_op)
            AOP_SUB: w_alu_ctrl = ALU_SUB;
            AOP_AND: w_alu_ctrl = ALU_AND;
            AOP_FUNCT: begin
                w_funct_ok = 1'b1;
                case (w_funct)
                    FN_ADD:  w_alu_ctrl = ALU_ADD;
                    FN_SUB:  w_alu_ctrl = ALU_SUB;
                    FN_AND:  w_alu_ctrl = ALU_AND;
                    FN_OR:   w_alu_ctrl = ALU_OR;
                    FN_SLT:  w_alu_ctrl = ALU_SLT;
                    default: w_funct_ok = 1'b0;
                endcase
            end
            default: w_alu_ctrl = ALU_ADD;
        endcase
    end

    // Main decoder; unknown opcodes keep all defaults and retire as nop
    always_comb begin
        w_reg_write  = 1'b0;
        w_reg_dst    = 1'b0;
        w_alu_src    = 1'b0;
        w_ext_zero   = 1'b0;
        w_mem_to_reg = 1'b0;
        w_mem_write  = 1'b0;
        w_branch_eq  = 1'b0;
        w_branch_ne  = 1'b0;
        w_jump       = 1'b0;
        w_alu_op     = AOP_ADD;
        case (w_opcode)
            OP_RTYPE: begin
                w_alu_op    = AOP_FUNCT;
                w_reg_dst   = 1'b1;
                w_reg_write = w_funct_ok;
            end
            OP_ADDI: begin
                w_alu_src   = 1'b1;
                w_reg_write = 1'b1;
            end
            OP_ANDI: begin
                w_alu_src   = 1'b1;
                w_ext_zero  = 1'b1;
                w_alu_op    = AOP_AND;
                w_reg_write = 1'b1;
            end
            OP_LW: begin
                w_alu_src    = 1'b1;
                w_mem_to_reg = 1'b1;
                w_reg_write  = 1'b1;
            end
            OP_SW: begin
                w_alu_src   = 1'b1;
                w_mem_write = 1'b1;
            end
            OP_BEQ: begin
                w_alu_op    = AOP_SUB;
                w_branch_eq = 1'b1;
            end
            OP_BNE: begin
                w_alu_op    = AOP_SUB;
                w_branch_ne = 1'b1;
            end
            OP_J: begin
`ifdef SC_JUMP_EN
                w_jump = 1'b1;
`else
                w_jump = 1'b0;
`endif
            end
            default: w_reg_write = 1'b0;
        endcase
    end

    reg_file get_reg (
        .clk     (clk),
        .i_reset (reset),
        .i_we    (w_reg_write),
        .i_ra1   (w_rs),
        .i_ra2   (w_rt),
        .i_wa    (w_wb_addr),
        .i_wd    (w_wb_data),
        .o_rd1_c (w_rd1),
        .o_rd2_c (w_rd2)
    );

    assign w_alu_b = !w_alu_src ? w_rd2 : (w_ext_zero ? w_imm_zext : w_imm_sext);

    // ALU: wrapping two's complement, signed slt
    always_comb begin
        w_alu_result = 32'd0;
        case (w_alu_ctrl)
            ALU_ADD: w_alu_result = w_rd1 + w_alu_b;
            ALU_SUB: w_alu_result = w_rd1 - w_alu_b;
            ALU_AND: w_alu_result = w_rd1 & w_alu_b;
            ALU_OR:  w_alu_result = w_rd1 | w_alu_b;
            ALU_SLT: w_alu_result = {31'd0, $signed(w_rd1) < $signed(w_alu_b)};
            default: w_alu_result = 32'd0;
        endcase
    end

    assign w_dmem_idx   = w_alu_result[DMEM_AW+1:2];
    assign w_dmem_rdata = r_dmem[w_dmem_idx];
    assign w_wb_data    = w_mem_to_reg ? w_dmem_rdata : w_alu_result;
    assign w_wb_addr    = w_reg_dst ? w_rd : w_rt;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DMEM_WORDS); i++) begin
                r_dmem[i] <= 32'd0;
            end
        end else if (w_mem_write) begin
            r_dmem[w_dmem_idx] <= w_rd2;
        end
    end

    // Next-PC selection
    assign w_pc_plus4      = PC_out + 32'd4;
    assign w_branch_target = w_pc_plus4 + {w_imm_sext[29:0], 2'b00};
    assign w_jump_target   = {w_pc_plus4[31:28], w_instr[25:0], 2'b00};
    assign w_take_branch   = (w_branch_eq & (w_rd1 == w_rd2)) | (w_branch_ne & (w_rd1 != w_rd2));

    always_comb begin
        w_next_pc = w_pc_plus4;
        if (w_jump) begin
            w_next_pc = w_jump_target;
        end else if (w_take_branch) begin
            w_next_pc = w_branch_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            PC_out <= 32'd0;
        end else begin
            PC_out <= w_next_pc;
        end
    end
endmodule

// 32x32 register file: two combinational reads, one write per edge, $0 hard-wired to zero.
module reg_file (
    input  logic        clk,
    input  logic        i_reset,
    input  logic        i_we,
    input  logic [4:0]  i_ra1,
    input  logic [4:0]  i_ra2,
    input  logic [4:0]  i_wa,
    input  logic [31:0] i_wd,
    output logic [31:0] o_rd1_c,
    output logic [31:0] o_rd2_c
);
    logic [31:0] register_memory [0:31];

    always_ff @(posedge clk) begin
        if (i_reset) begin
            for (int i = 0; i < 32; i++) begin
                register_memory[i] <= 32'd0;
            end
        end else if (i_we && (i_wa != 5'd0)) begin
            register_memory[i_wa] <= i_wd;
        end
    end

    assign o_rd1_c = (i_ra1 == 5'd0) ? 32'd0 : register_memory[i_ra1];
    assign o_rd2_c = (i_ra2 == 5'd0) ? 32'd0 : register_memory[i_ra2];
endmodule

// File: tb/tb_single_cycle_cpu.sv
// Directed bench for single_cycle_cpu: loads small programs into the ROM and checks PC, registers and RAM.
module tb_single_cycle_cpu;
    logic        clk;
    logic        reset;
    logic [31:0] pc_out;

    int n_checks;
    int n_errors;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    localparam logic [4:0] ZERO = 5'd0;
    localparam logic [4:0] T0 = 5'd8;
    localparam logic [4:0] T1 = 5'd9;
    localparam logic [4:0] T2 = 5'd10;
    localparam logic [4:0] T3 = 5'd11;
    localparam logic [4:0] T4 = 5'd12;
    localparam logic [4:0] T5 = 5'd13;
    localparam logic [4:0] T6 = 5'd14;
    localparam logic [4:0] T7 = 5'd15;
    localparam logic [4:0] S0 = 5'd16;
    localparam logic [4:0] S1 = 5'd17;
    localparam logic [4:0] S2 = 5'd18;
    localparam logic [4:0] S3 = 5'd19;

`ifdef SC_JUMP_EN
    localparam logic [31:0] EXP_J_PC = 32'h0000_0040;
`else
    localparam logic [31:0] EXP_J_PC = 32'h0000_0024;
`endif

    single_cycle_cpu dut (
        .clk    (clk),
        .reset  (reset),
        .pc_out (pc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {OP_R, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 64; i++) dut.r_imem[i] = 32'd0;
    endtask

    function automatic logic [31:0] reg_val(input int idx);
        return dut.get_reg.register_memory[idx];
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;

        // Program A: arithmetic, logic, memory, $0 protection
        clear_rom();
        dut.r_imem[3]  = itype(OP_ADDI, ZERO, S0, 16'd5);
        dut.r_imem[4]  = itype(OP_ADDI, ZERO, S1, 16'hFFFD);
        dut.r_imem[5]  = rtype(S0, S1, S2, 6'b100000);
        dut.r_imem[6]  = rtype(S1, S0, T0, 6'b100010);
        dut.r_imem[7]  = rtype(S1, S0, T1, 6'b101010);
        dut.r_imem[8]  = itype(OP_ADDI, ZERO, T3, 16'h00F0);
        dut.r_imem[9]  = itype(OP_ADDI, ZERO, T4, 16'h003C);
        dut.r_imem[10] = rtype(T3, T4, T5, 6'b100100);
        dut.r_imem[11] = rtype(T3, T4, T6, 6'b100101);
        dut.r_imem[12] = itype(OP_SW, ZERO, S0, 16'd4);
        dut.r_imem[13] = itype(OP_LW, ZERO, T2, 16'd4);
        dut.r_imem[14] = itype(OP_ADDI, ZERO, ZERO, 16'd7);
        dut.r_imem[15] = itype(OP_ANDI, S1, T7, 16'hFFFF);

        tick(2);
        reset = 1'b0;
        check("reset_pc", pc_out, 32'd0);
        for (int r = 16; r <= 25; r++) check($sformatf("reset_reg%0d", r), reg_val(r), 32'd0);
        tick(3);
        check("nop_pc", pc_out, 32'h0000_000C);
        tick(3);
        check("addi_s0", reg_val(16), 32'h0000_0005);
        check("addi_s1_neg", reg_val(17), 32'hFFFF_FFFD);
        check("add_s2", reg_val(18), 32'h0000_0002);
        tick(2);
        check("sub_t0", reg_val(8), 32'hFFFF_FFF8);
        check("slt_signed", reg_val(9), 32'h0000_0001);
        tick(4);
        check("and_t5", reg_val(13), 32'h0000_0030);
        check("or_t6", reg_val(14), 32'h0000_00FC);
        tick(1);
        check("sw_ram", dut.r_dmem[1], 32'h0000_0005);
        tick(1);
        check("lw_t2", reg_val(10), 32'h0000_0005);
        tick(1);
        check("zero_reg", reg_val(0), 32'd0);
        tick(1);
        check("andi_zext", reg_val(15), 32'h0000_FFFD);
        check("pc_after_a", pc_out, 32'h0000_0040);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("rst_ram", dut.r_dmem[1], 32'd0);
        check("rst_t2", reg_val(10), 32'd0);

        // Program B: unsupported encodings, branches, jump, mid-run reset
        reset = 1'b1;
        clear_rom();
        dut.r_imem[0] = itype(OP_ADDI, ZERO, S0, 16'd5);
        dut.r_imem[1] = itype(OP_BAD, ZERO, T0, 16'h1234);
        dut.r_imem[2] = rtype(S0, S0, T1, 6'b100001);
        dut.r_imem[4] = itype(OP_BEQ, S0, S0, 16'd2);
        dut.r_imem[7] = itype(OP_BNE, S0, S0, 16'd2);
        dut.r_imem[8] = {OP_J, 26'h10};
        tick(1);
        reset = 1'b0;
        check("b_reset_pc", pc_out, 32'd0);
        tick(1);
        check("b_pc4", pc_out, 32'h0000_0004);
        tick(3);
        check("b_pc10", pc_out, 32'h0000_0010);
        check("bad_op_nop", reg_val(8), 32'd0);
        check("bad_funct_nop", reg_val(9), 32'd0);
        tick(1);
        check("beq_taken", pc_out, 32'h0000_001C);
        tick(1);
        check("bne_not_taken", pc_out, 32'h0000_0020);
        tick(1);
        check("jump_pc", pc_out, EXP_J_PC);
        tick(1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("midrun_reset_pc", pc_out, 32'd0);
        check("midrun_reset_s0", reg_val(16), 32'd0);

        // Program C: fetches past the ROM must read as nop, not wrap to word 0
        reset = 1'b1;
        clear_rom();
        dut.r_imem[0] = itype(OP_ADDI, S3, S3, 16'd1);
        tick(1);
        reset = 1'b0;
        tick(64);
        check("rom_end_pc", pc_out, 32'h0000_0100);
        check("rom_end_s3", reg_val(19), 32'd1);
        tick(2);
        check("past_rom_pc", pc_out, 32'h0000_0108);
        check("past_rom_nop", reg_val(19), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
